// File: rtl/div_stall_unit.sv
// div_stall_unit: multi-cycle radix-2 restoring divider for DIV/DIVU that stalls the
// execute stage for 33 cycles, then pulses div_validE with registered hiE/loE.
module div_stall_unit #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        startE,
    input  logic        signedE,
    input  logic [31:0] srcaE,
    input  logic [31:0] srcbE,
    input  logic        annulE,
    output logic        stall_divE,
    output logic        div_validE,
    output logic [31:0] hiE,
    output logic [31:0] loE
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t      state_q, state_d;
    logic [5:0]  cnt_q;
    logic [63:0] rem_q, rem_d;
    logic [31:0] dvs_q, hi_q, lo_q, q_fin, r_fin;
    logic        negq_q, negr_q, dz_q;
    logic [32:0] a_mag, b_mag, t, sub;
    logic        ge, go, last;
    always_comb begin
        a_mag   = (signedE && srcaE[31]) ? 33'd0 - {1'b1, srcaE} : {1'b0, srcaE};
        b_mag   = (signedE && srcbE[31]) ? 33'd0 - {1'b1, srcbE} : {1'b0, srcbE};
        // remainder stays below the divisor, so the shifted value always fits in 33 bits
        t       = rem_q[63:31];
        ge      = t >= {1'b0, dvs_q};
        sub     = t - {1'b0, dvs_q};
        rem_d   = {ge ? sub[31:0] : t[31:0], rem_q[30:0], ge};
        q_fin   = negq_q ? 32'd0 - rem_d[31:0] : rem_d[31:0];
        r_fin   = negr_q ? 32'd0 - rem_d[63:32] : rem_d[63:32];
        go      = state_q == IDLE && startE && !annulE;
        last    = state_q == BUSY && cnt_q == 6'(ITER - 1);
        state_d = annulE ? IDLE :
                  go ? BUSY :
                  last ? DONE :
                  state_q == DONE ? IDLE : state_q;
        stall_divE = state_q == IDLE ? go : state_q == BUSY && !annulE;
        div_validE = state_q == DONE && !annulE;
    end
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (go) begin
                cnt_q  <= '0;
                rem_q  <= {32'd0, a_mag[31:0]};
                dvs_q  <= b_mag[31:0];
                negq_q <= signedE && (srcaE[31] ^ srcbE[31]) && srcbE != 32'd0;
                negr_q <= signedE && srcaE[31];
                dz_q   <= srcbE == 32'd0;
            end else if (state_q == BUSY && !annulE) begin
                cnt_q <= cnt_q + 6'd1;
                rem_q <= rem_d;
                if (last) begin
                    // a zero divisor leaves the raw dividend as remainder; quotient is forced to all ones
                    hi_q <= r_fin;
                    lo_q <= dz_q ? 32'hFFFF_FFFF : q_fin;
                end
            end
        end
    end
    assign hiE = hi_q;
    assign loE = lo_q;
endmodule

// File: tb/tb_div_stall_unit.sv
// tb_div_stall_unit: directed and random checks of divide latency, results, annul and reset,
// with expected {hi,lo} queued at issue and compared whenever div_validE pulses.
module tb_div_stall_unit;
    logic        clk = 1'b0;
    logic        resetn, startE, signedE, annulE;
    logic [31:0] srcaE, srcbE;
    logic        stall_divE, div_validE;
    logic [31:0] hiE, loE;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_valid = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_exp = 64'd0;

    div_stall_unit #(.ITER(32)) dut (
        .clk(clk), .resetn(resetn), .startE(startE), .signedE(signedE),
        .srcaE(srcaE), .srcbE(srcbE), .annulE(annulE),
        .stall_divE(stall_divE), .div_validE(div_validE), .hiE(hiE), .loE(loE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
    endfunction

    always @(negedge clk) begin
        if (resetn && div_validE) begin
            logic [63:0] e;
            n_valid++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $error("FAIL unexpected_valid: observed hi=%h lo=%h expected no pulse", hiE, loE);
            end else begin
                e = exp_q.pop_front();
                chk("hi", hiE, e[63:32]);
                chk("lo", loE, e[31:0]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] e, input logic hold);
        startE = 1'b1; signedE = s; srcaE = a; srcbE = b;
        #1;
        chk1("stall_T", stall_divE, 1'b1);
        exp_q.push_back(e);
        last_exp = e;
        for (int i = 1; i <= 32; i++) begin
            cyc();
            startE = hold;
            #1;
            chk1("stall_busy", stall_divE, 1'b1);
            chk1("valid_busy", div_validE, 1'b0);
        end
        cyc();
        #1;
        chk1("stall_done", stall_divE, 1'b0);
        chk1("valid_done", div_validE, 1'b1);
    endtask

    initial begin
        int v0;
        logic s;
        logic [31:0] a, b;
        resetn = 1'b0; startE = 1'b1; signedE = 1'b0; annulE = 1'b0; srcaE = 32'd55; srcbE = 32'd3;
        repeat (3) cyc();
        startE = 1'b0;
        #1;
        chk1("rst_stall", stall_divE, 1'b0);
        chk1("rst_valid", div_validE, 1'b0);
        chk("rst_hi", hiE, 32'd0);
        chk("rst_lo", loE, 32'd0);
        cyc();
        resetn = 1'b1;
        cyc();
        // unsigned 100/7
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0);
        cyc();
        #1;
        chk1("idle_stall", stall_divE, 1'b0);
        chk1("idle_valid", div_validE, 1'b0);
        // signed -7/2 and overflow case
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        cyc();
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0);
        cyc();
        // divide by zero, both modes
        do_div(1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b0);
        cyc();
        do_div(1'b1, 32'hFFFF_FF00, 32'd0, {32'hFFFF_FF00, 32'hFFFF_FFFF}, 1'b0);
        cyc();
        // annul at T+10
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd999; srcbE = 32'd5;
        #1;
        chk1("annul_stall_T", stall_divE, 1'b1);
        for (int i = 1; i <= 9; i++) begin
            cyc();
            startE = 1'b0;
        end
        cyc();
        annulE = 1'b1;
        #1;
        chk1("annul_stall", stall_divE, 1'b0);
        chk1("annul_valid", div_validE, 1'b0);
        cyc();
        annulE = 1'b0;
        #1;
        chk1("post_annul_stall", stall_divE, 1'b0);
        chk("annul_hi_keep", hiE, last_exp[63:32]);
        chk("annul_lo_keep", loE, last_exp[31:0]);
        repeat (40) cyc();
        // annul together with start is no start
        startE = 1'b1; annulE = 1'b1;
        #1;
        chk1("annul_start_stall", stall_divE, 1'b0);
        cyc();
        startE = 1'b0; annulE = 1'b0;
        #1;
        chk1("annul_start_idle", stall_divE, 1'b0);
        repeat (40) cyc();
        // back-to-back with startE held through DONE
        v0 = n_valid;
        do_div(1'b0, 32'd1000, 32'd33, model(1'b0, 32'd1000, 32'd33), 1'b1);
        cyc();
        do_div(1'b1, 32'hFFFF_FC18, 32'd7, model(1'b1, 32'hFFFF_FC18, 32'd7), 1'b0);
        cyc();
        #1;
        chk1("b2b_idle_stall", stall_divE, 1'b0);
        repeat (5) cyc();
        chk("b2b_pulses", 32'(n_valid - v0), 32'd2);
        // random operands against the model
        for (int k = 0; k < 6; k++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom();
            b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 50)) : $urandom();
            do_div(s, a, b, model(s, a, b), 1'b0);
            cyc();
        end
        // reset at T+5 for one cycle
        startE = 1'b1; signedE = 1'b0; srcaE = 32'd77; srcbE = 32'd4;
        #1;
        chk1("rstmid_stall_T", stall_divE, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            cyc();
            startE = 1'b0;
        end
        resetn = 1'b0;
        startE = 1'b1;
        cyc();
        resetn = 1'b1;
        startE = 1'b0;
        #1;
        chk1("rstmid_stall", stall_divE, 1'b0);
        chk1("rstmid_valid", div_validE, 1'b0);
        chk("rstmid_hi", hiE, 32'd0);
        chk("rstmid_lo", loE, 32'd0);
        startE = 1'b1;
        #1;
        chk1("rstmid_stall_follows_start", stall_divE, 1'b1);
        startE = 1'b0;
        repeat (40) cyc();
        chk("rstmid_hi_hold", hiE, 32'd0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        repeat (3) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
